// File: rtl/el2_mem_bank_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// el2_mem_bank_arb_if : requester and SRAM-bank bus of el2_mem_bank_arb
// Rev 1.0
// ----------------------------------------------------------------------------
interface el2_mem_bank_arb_if #(
   parameter int NUM_PORTS = 2,
   parameter int NUM_BANKS = 4,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int ECC_W     = 7
);
   localparam int BANK_BITS = $clog2(NUM_BANKS);
   localparam int ROW_W     = ADDR_W - BANK_BITS;

   logic [NUM_PORTS-1:0]         req_valid;
   logic [NUM_PORTS-1:0]         req_ready;
   logic [NUM_PORTS-1:0]         req_we;
   logic [NUM_PORTS*ADDR_W-1:0]  req_addr;
   logic [NUM_PORTS*DATA_W-1:0]  req_wdata;
   logic [NUM_PORTS*ECC_W-1:0]   req_wecc;
   logic [NUM_PORTS-1:0]         rsp_valid;
   logic [NUM_PORTS*DATA_W-1:0]  rsp_rdata;
   logic [NUM_PORTS*ECC_W-1:0]   rsp_recc;
   logic [NUM_BANKS-1:0]         mem_clken;
   logic [NUM_BANKS-1:0]         mem_wren_bank;
   logic [NUM_BANKS*ROW_W-1:0]   mem_addr_bank;
   logic [NUM_BANKS*DATA_W-1:0]  mem_wr_data_bank;
   logic [NUM_BANKS*ECC_W-1:0]   mem_wr_ecc_bank;
   logic [NUM_BANKS*DATA_W-1:0]  mem_bank_dout;
   logic [NUM_BANKS*ECC_W-1:0]   mem_bank_ecc;

   // master is the surrounding environment: requesters plus the SRAM sink
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wecc,
      output mem_bank_dout, mem_bank_ecc,
      input  req_ready, rsp_valid, rsp_rdata, rsp_recc,
      input  mem_clken, mem_wren_bank, mem_addr_bank, mem_wr_data_bank, mem_wr_ecc_bank
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wecc,
      input  mem_bank_dout, mem_bank_ecc,
      output req_ready, rsp_valid, rsp_rdata, rsp_recc,
      output mem_clken, mem_wren_bank, mem_addr_bank, mem_wr_data_bank, mem_wr_ecc_bank
   );
endinterface
`default_nettype wire

// File: rtl/el2_mem_bank_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// el2_mem_bank_arb : banked CCM SRAM front end, per-bank round-robin, zero-fill
// Rev 1.0
// ----------------------------------------------------------------------------
module el2_mem_bank_arb #(
   parameter int               NUM_PORTS = 2,
   parameter int               NUM_BANKS = 4,
   parameter int               ADDR_W    = 16,
   parameter int               DATA_W    = 32,
   parameter int               ECC_W     = 7,
   parameter logic [ECC_W-1:0] ZERO_ECC  = '0,
   parameter int               RD_LAT    = 1,
   parameter bit               INIT_EN   = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   el2_mem_bank_arb_if.slave  bus,
   output logic               init_done
);
   localparam int BANK_BITS = $clog2(NUM_BANKS);
   localparam int ROW_W     = ADDR_W - BANK_BITS;
   localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [ROW_W-1:0] LAST_ROW = '1;

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [ROW_W-1:0] row, row_nxt;
   logic             done_nxt;
   logic             init_drive;
   logic             run;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_INIT;
         row       <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         row       <= row_nxt;
         init_done <= done_nxt;
      end
   end

   // rst gates the drive terms so every output reads 0 while reset is held
   always_comb begin
      state_nxt  = state;
      row_nxt    = row;
      done_nxt   = init_done;
      init_drive = 1'b0;
      run        = 1'b0;
      case (state)
         S_INIT: begin
            if (INIT_EN) begin
               init_drive = ~rst;
               row_nxt    = row + 1'b1;
               if (row == LAST_ROW) begin
                  state_nxt = S_RUN;
                  done_nxt  = 1'b1;
               end
            end else begin
               state_nxt = S_RUN;
               done_nxt  = 1'b1;
            end
         end
         S_RUN:   run = ~rst;
         default: state_nxt = S_INIT;
      endcase
   end

   logic [BANK_BITS-1:0] p_bank  [NUM_PORTS];
   logic [ROW_W-1:0]     p_row   [NUM_PORTS];
   logic [DATA_W-1:0]    p_wdata [NUM_PORTS];
   logic [ECC_W-1:0]     p_wecc  [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_unpack
      assign p_bank[p]  = bus.req_addr[p*ADDR_W +: BANK_BITS];
      assign p_row[p]   = bus.req_addr[p*ADDR_W+BANK_BITS +: ROW_W];
      assign p_wdata[p] = bus.req_wdata[p*DATA_W +: DATA_W];
      assign p_wecc[p]  = bus.req_wecc[p*ECC_W +: ECC_W];
   end

   logic [PORT_W-1:0]    rr_ptr   [NUM_BANKS];
   logic [PORT_W-1:0]    gnt_port [NUM_BANKS];
   logic [NUM_BANKS-1:0] gnt_any;
   logic [NUM_PORTS-1:0] ready;

   // Scan ports starting at the bank's pointer; first matching requester wins
   always_comb begin
      int idx;
      idx     = 0;
      gnt_any = '0;
      ready   = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         gnt_port[b] = '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr_ptr[b]) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (run && !gnt_any[b] && bus.req_valid[idx] && (p_bank[idx] == BANK_BITS'(b))) begin
               gnt_any[b]  = 1'b1;
               gnt_port[b] = PORT_W'(idx);
               ready[idx]  = 1'b1;
            end
         end
      end
   end

   assign bus.req_ready = ready;

   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (rst) begin
            rr_ptr[b] <= '0;
         end else if (gnt_any[b]) begin
            rr_ptr[b] <= (int'(gnt_port[b]) == NUM_PORTS - 1) ? '0 : gnt_port[b] + 1'b1;
         end
      end
   end

   logic [NUM_BANKS-1:0]        clken;
   logic [NUM_BANKS-1:0]        wren;
   logic [NUM_BANKS*ROW_W-1:0]  addr_bank;
   logic [NUM_BANKS*DATA_W-1:0] wdata_bank;
   logic [NUM_BANKS*ECC_W-1:0]  wecc_bank;

   always_comb begin
      clken      = '0;
      wren       = '0;
      addr_bank  = '0;
      wdata_bank = '0;
      wecc_bank  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (init_drive) begin
            clken[b]                      = 1'b1;
            wren[b]                       = 1'b1;
            addr_bank[b*ROW_W +: ROW_W]   = row;
            wecc_bank[b*ECC_W +: ECC_W]   = ZERO_ECC;
         end else if (gnt_any[b]) begin
            clken[b]                      = 1'b1;
            wren[b]                       = bus.req_we[gnt_port[b]];
            addr_bank[b*ROW_W +: ROW_W]   = p_row[gnt_port[b]];
            wdata_bank[b*DATA_W +: DATA_W] = p_wdata[gnt_port[b]];
            wecc_bank[b*ECC_W +: ECC_W]   = p_wecc[gnt_port[b]];
         end
      end
   end

   assign bus.mem_clken        = clken;
   assign bus.mem_wren_bank    = wren;
   assign bus.mem_addr_bank    = addr_bank;
   assign bus.mem_wr_data_bank = wdata_bank;
   assign bus.mem_wr_ecc_bank  = wecc_bank;

   logic [NUM_PORTS-1:0] rd_v1;
   logic [BANK_BITS-1:0] rd_bank1 [NUM_PORTS];
   logic [DATA_W-1:0]    mux_data [NUM_PORTS];
   logic [ECC_W-1:0]     mux_ecc  [NUM_PORTS];

   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rst) begin
            rd_v1[p]    <= 1'b0;
            rd_bank1[p] <= '0;
         end else begin
            rd_v1[p] <= ready[p] & ~bus.req_we[p];
            if (ready[p]) rd_bank1[p] <= p_bank[p];
         end
      end
   end

   // Bank output is valid the cycle after the read, when stage 1 holds the bank index
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp_mux
      assign mux_data[p] = bus.mem_bank_dout[int'(rd_bank1[p])*DATA_W +: DATA_W];
      assign mux_ecc[p]  = bus.mem_bank_ecc[int'(rd_bank1[p])*ECC_W +: ECC_W];
   end

   if (RD_LAT == 2) begin : g_lat2
      logic [NUM_PORTS-1:0]        v2;
      logic [NUM_PORTS*DATA_W-1:0] d2;
      logic [NUM_PORTS*ECC_W-1:0]  e2;

      always_ff @(posedge clk) begin
         if (rst) begin
            v2 <= '0;
            d2 <= '0;
            e2 <= '0;
         end else begin
            v2 <= rd_v1;
            for (int p = 0; p < NUM_PORTS; p++) begin
               if (rd_v1[p]) begin
                  d2[p*DATA_W +: DATA_W] <= mux_data[p];
                  e2[p*ECC_W +: ECC_W]   <= mux_ecc[p];
               end
            end
         end
      end

      assign bus.rsp_valid = v2;
      assign bus.rsp_rdata = d2;
      assign bus.rsp_recc  = e2;
   end else begin : g_lat1
      logic [NUM_PORTS*DATA_W-1:0] d1;
      logic [NUM_PORTS*ECC_W-1:0]  e1;

      always_comb begin
         d1 = '0;
         e1 = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            d1[p*DATA_W +: DATA_W] = mux_data[p];
            e1[p*ECC_W +: ECC_W]   = mux_ecc[p];
         end
      end

      assign bus.rsp_valid = rd_v1;
      assign bus.rsp_rdata = d1;
      assign bus.rsp_recc  = e1;
   end
endmodule
`default_nettype wire

// File: tb/tb_el2_mem_bank_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_el2_mem_bank_arb : directed checks of el2_mem_bank_arb (RD_LAT 1 with init, RD_LAT 2 without)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_el2_mem_bank_arb;
   localparam logic [6:0] ZE = 7'h2C;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic done_a, done_b;
   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   el2_mem_bank_arb_if #(.NUM_PORTS(2), .NUM_BANKS(4), .ADDR_W(6), .DATA_W(32), .ECC_W(7)) bus_a ();
   el2_mem_bank_arb_if #(.NUM_PORTS(2), .NUM_BANKS(4), .ADDR_W(6), .DATA_W(32), .ECC_W(7)) bus_b ();

   el2_mem_bank_arb #(.NUM_PORTS(2), .NUM_BANKS(4), .ADDR_W(6), .DATA_W(32), .ECC_W(7),
                      .ZERO_ECC(ZE), .RD_LAT(1), .INIT_EN(1'b1))
   u_a (.clk(clk), .rst(rst_a), .bus(bus_a), .init_done(done_a));

   el2_mem_bank_arb #(.NUM_PORTS(2), .NUM_BANKS(4), .ADDR_W(6), .DATA_W(32), .ECC_W(7),
                      .ZERO_ECC(ZE), .RD_LAT(2), .INIT_EN(1'b0))
   u_b (.clk(clk), .rst(rst_b), .bus(bus_b), .init_done(done_b));

   function automatic logic [31:0] pat_d(int b, int r);
      return 32'hC0DE0000 | 32'(b << 8) | 32'(r);
   endfunction

   function automatic logic [6:0] pat_e(int b, int r);
      return 7'(b * 16 + r);
   endfunction

   // SRAM sink models: one-cycle read latency, pattern-filled while reset is held
   logic [31:0]  mem_a_d [4][16];
   logic [6:0]   mem_a_e [4][16];
   logic [127:0] dout_a;
   logic [27:0]  ecc_a;
   logic [31:0]  mem_b_d [4][16];
   logic [6:0]   mem_b_e [4][16];
   logic [127:0] dout_b;
   logic [27:0]  ecc_b;

   assign bus_a.mem_bank_dout = dout_a;
   assign bus_a.mem_bank_ecc  = ecc_a;
   assign bus_b.mem_bank_dout = dout_b;
   assign bus_b.mem_bank_ecc  = ecc_b;

   always @(posedge clk) begin
      if (rst_a) begin
         for (int b = 0; b < 4; b++)
            for (int r = 0; r < 16; r++) begin
               mem_a_d[b][r] <= pat_d(b, r);
               mem_a_e[b][r] <= pat_e(b, r);
            end
         dout_a <= '0;
         ecc_a  <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus_a.mem_clken[b]) begin
               if (bus_a.mem_wren_bank[b]) begin
                  mem_a_d[b][bus_a.mem_addr_bank[b*4 +: 4]] <= bus_a.mem_wr_data_bank[b*32 +: 32];
                  mem_a_e[b][bus_a.mem_addr_bank[b*4 +: 4]] <= bus_a.mem_wr_ecc_bank[b*7 +: 7];
               end else begin
                  dout_a[b*32 +: 32] <= mem_a_d[b][bus_a.mem_addr_bank[b*4 +: 4]];
                  ecc_a[b*7 +: 7]    <= mem_a_e[b][bus_a.mem_addr_bank[b*4 +: 4]];
               end
            end
      end
   end

   always @(posedge clk) begin
      if (rst_b) begin
         for (int b = 0; b < 4; b++)
            for (int r = 0; r < 16; r++) begin
               mem_b_d[b][r] <= pat_d(b, r);
               mem_b_e[b][r] <= pat_e(b, r);
            end
         dout_b <= '0;
         ecc_b  <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus_b.mem_clken[b]) begin
               if (bus_b.mem_wren_bank[b]) begin
                  mem_b_d[b][bus_b.mem_addr_bank[b*4 +: 4]] <= bus_b.mem_wr_data_bank[b*32 +: 32];
                  mem_b_e[b][bus_b.mem_addr_bank[b*4 +: 4]] <= bus_b.mem_wr_ecc_bank[b*7 +: 7];
               end else begin
                  dout_b[b*32 +: 32] <= mem_b_d[b][bus_b.mem_addr_bank[b*4 +: 4]];
                  ecc_b[b*7 +: 7]    <= mem_b_e[b][bus_b.mem_addr_bank[b*4 +: 4]];
               end
            end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  valid, we;
      logic [5:0]  a0, a1;
      logic [31:0] wd;
      logic [6:0]  wc;
      logic [1:0]  e_ready;
      logic [3:0]  e_clken, e_wren;
      logic [1:0]  e_rsp;
      logic [31:0] e_rd0, e_rd1;
      logic [6:0]  e_re0, e_re1;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] v, we, input logic [5:0] a0, a1,
                               input logic [31:0] wd, input logic [6:0] wc,
                               input logic [1:0] er, input logic [3:0] ec, ew,
                               input logic [1:0] ers, input logic [31:0] rd0,
                               input logic [6:0] re0, input logic [31:0] rd1,
                               input logic [6:0] re1);
      vec_t t;
      t.valid = v;   t.we = we;     t.a0 = a0;     t.a1 = a1;
      t.wd = wd;     t.wc = wc;     t.e_ready = er;
      t.e_clken = ec; t.e_wren = ew; t.e_rsp = ers;
      t.e_rd0 = rd0; t.e_re0 = re0; t.e_rd1 = rd1; t.e_re1 = re1;
      return t;
   endfunction

   localparam int NV = 15;
   vec_t tbl [NV];

   initial begin
      // Post-init traffic for u_a; RR pointers start at 0 in every bank
      tbl[0]  = mk(2'b11, 2'b01, 6'h05, 6'h06, 32'hDEADBEEF, 7'h11, 2'b11, 4'b0110, 4'b0010, 2'b00, 0, 0, 0, 0);
      tbl[1]  = mk(2'b01, 2'b00, 6'h05, 6'h00, 0, 0, 2'b01, 4'b0010, 4'b0000, 2'b10, 0, 0, 32'h0, ZE);
      tbl[2]  = mk(2'b00, 2'b00, 6'h00, 6'h00, 0, 0, 2'b00, 4'b0000, 4'b0000, 2'b01, 32'hDEADBEEF, 7'h11, 0, 0);
      tbl[3]  = mk(2'b11, 2'b00, 6'h04, 6'h08, 0, 0, 2'b01, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0);
      tbl[4]  = mk(2'b11, 2'b00, 6'h04, 6'h08, 0, 0, 2'b10, 4'b0001, 4'b0000, 2'b01, 32'h0, ZE, 0, 0);
      tbl[5]  = mk(2'b11, 2'b00, 6'h04, 6'h08, 0, 0, 2'b01, 4'b0001, 4'b0000, 2'b10, 0, 0, 32'h0, ZE);
      tbl[6]  = mk(2'b11, 2'b00, 6'h04, 6'h08, 0, 0, 2'b10, 4'b0001, 4'b0000, 2'b01, 32'h0, ZE, 0, 0);
      tbl[7]  = mk(2'b00, 2'b00, 6'h00, 6'h00, 0, 0, 2'b00, 4'b0000, 4'b0000, 2'b10, 0, 0, 32'h0, ZE);
      tbl[8]  = mk(2'b11, 2'b01, 6'h07, 6'h0B, 32'h12345678, 7'h22, 2'b01, 4'b1000, 4'b1000, 2'b00, 0, 0, 0, 0);
      tbl[9]  = mk(2'b11, 2'b00, 6'h07, 6'h0B, 0, 0, 2'b10, 4'b1000, 4'b0000, 2'b00, 0, 0, 0, 0);
      tbl[10] = mk(2'b01, 2'b00, 6'h07, 6'h00, 0, 0, 2'b01, 4'b1000, 4'b0000, 2'b10, 0, 0, 32'h0, ZE);
      tbl[11] = mk(2'b00, 2'b00, 6'h00, 6'h00, 0, 0, 2'b00, 4'b0000, 4'b0000, 2'b01, 32'h12345678, 7'h22, 0, 0);
      tbl[12] = mk(2'b10, 2'b10, 6'h00, 6'h0E, 32'hA5A55A5A, 7'h33, 2'b10, 4'b0100, 4'b0100, 2'b00, 0, 0, 0, 0);
      tbl[13] = mk(2'b10, 2'b00, 6'h00, 6'h0E, 0, 0, 2'b10, 4'b0100, 4'b0000, 2'b00, 0, 0, 0, 0);
      tbl[14] = mk(2'b00, 2'b00, 6'h00, 6'h00, 0, 0, 2'b00, 4'b0000, 4'b0000, 2'b10, 0, 0, 32'hA5A55A5A, 7'h33);

      bus_a.req_valid = '0; bus_a.req_we = '0; bus_a.req_addr = '0;
      bus_a.req_wdata = '0; bus_a.req_wecc = '0;
      bus_b.req_valid = '0; bus_b.req_we = '0; bus_b.req_addr = '0;
      bus_b.req_wdata = '0; bus_b.req_wecc = '0;

      // ---- u_a: zero-fill init, aborted at row 9 then rerun in full
      repeat (3) @(negedge clk);
      #1;
      chk("rst_clken", 64'(bus_a.mem_clken), 64'h0);
      chk("rst_done", 64'(done_a), 64'h0);
      @(negedge clk);
      rst_a = 1'b0;
      bus_a.req_valid = 2'b11;
      bus_a.req_addr  = {6'h08, 6'h04};
      for (int k = 0; k <= 9; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk($sformatf("init1_r%0d_wren", k), 64'(bus_a.mem_wren_bank), 64'hF);
         chk($sformatf("init1_r%0d_addr", k), 64'(bus_a.mem_addr_bank), 64'({4{4'(k)}}));
         chk($sformatf("init1_r%0d_ready", k), 64'(bus_a.req_ready), 64'h0);
      end
      rst_a = 1'b1;
      #1;
      chk("midrst_clken", 64'(bus_a.mem_clken), 64'h0);
      @(negedge clk);
      rst_a = 1'b0;
      for (int k = 0; k <= 15; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk($sformatf("init2_r%0d_clken", k), 64'(bus_a.mem_clken), 64'hF);
         chk($sformatf("init2_r%0d_wren", k), 64'(bus_a.mem_wren_bank), 64'hF);
         chk($sformatf("init2_r%0d_addr", k), 64'(bus_a.mem_addr_bank), 64'({4{4'(k)}}));
         chk($sformatf("init2_r%0d_wdata", k), 64'(|bus_a.mem_wr_data_bank), 64'h0);
         chk($sformatf("init2_r%0d_wecc", k), 64'(bus_a.mem_wr_ecc_bank), 64'({4{ZE}}));
         chk($sformatf("init2_r%0d_ready", k), 64'(bus_a.req_ready), 64'h0);
         chk($sformatf("init2_r%0d_done", k), 64'(done_a), 64'h0);
      end
      @(negedge clk);
      bus_a.req_valid = 2'b00;
      #1;
      chk("init_done_c16", 64'(done_a), 64'h1);
      chk("idle_clken_c16", 64'(bus_a.mem_clken), 64'h0);

      // ---- u_a: table of RUN-mode vectors
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         bus_a.req_valid = tbl[i].valid;
         bus_a.req_we    = tbl[i].we;
         bus_a.req_addr  = {tbl[i].a1, tbl[i].a0};
         bus_a.req_wdata = {2{tbl[i].wd}};
         bus_a.req_wecc  = {2{tbl[i].wc}};
         #1;
         chk($sformatf("v%0d_ready", i), 64'(bus_a.req_ready), 64'(tbl[i].e_ready));
         chk($sformatf("v%0d_clken", i), 64'(bus_a.mem_clken), 64'(tbl[i].e_clken));
         chk($sformatf("v%0d_wren", i), 64'(bus_a.mem_wren_bank), 64'(tbl[i].e_wren));
         chk($sformatf("v%0d_rsp_valid", i), 64'(bus_a.rsp_valid), 64'(tbl[i].e_rsp));
         if (tbl[i].e_rsp[0]) begin
            chk($sformatf("v%0d_rdata0", i), 64'(bus_a.rsp_rdata[31:0]), 64'(tbl[i].e_rd0));
            chk($sformatf("v%0d_recc0", i), 64'(bus_a.rsp_recc[6:0]), 64'(tbl[i].e_re0));
         end
         if (tbl[i].e_rsp[1]) begin
            chk($sformatf("v%0d_rdata1", i), 64'(bus_a.rsp_rdata[63:32]), 64'(tbl[i].e_rd1));
            chk($sformatf("v%0d_recc1", i), 64'(bus_a.rsp_recc[13:7]), 64'(tbl[i].e_re1));
         end
      end

      // ---- u_b: no init, RD_LAT=2
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("b_c0_wren", 64'(bus_b.mem_wren_bank), 64'h0);
      @(negedge clk);
      bus_b.req_valid = 2'b01;
      bus_b.req_addr  = {6'h00, 6'h03};
      #1;
      chk("b_c1_done", 64'(done_b), 64'h1);
      chk("b_c1_ready", 64'(bus_b.req_ready), 64'h1);
      chk("b_c1_clken", 64'(bus_b.mem_clken), 64'h8);
      chk("b_c1_wren", 64'(bus_b.mem_wren_bank), 64'h0);
      @(negedge clk);
      bus_b.req_valid = 2'b00;
      #1;
      chk("b_lat_t1_valid", 64'(bus_b.rsp_valid), 64'h0);
      @(negedge clk);
      #1;
      chk("b_lat_t2_valid", 64'(bus_b.rsp_valid), 64'h1);
      chk("b_lat_t2_rdata", 64'(bus_b.rsp_rdata[31:0]), 64'(pat_d(3, 0)));
      chk("b_lat_t2_recc", 64'(bus_b.rsp_recc[6:0]), 64'(pat_e(3, 0)));
      @(negedge clk);
      #1;
      chk("b_lat_t3_valid", 64'(bus_b.rsp_valid), 64'h0);

      // four back-to-back reads of bank 3 rows 0..3
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         if (c < 4) begin
            bus_b.req_valid = 2'b01;
            bus_b.req_addr  = {6'h00, 4'(c), 2'b11};
         end else begin
            bus_b.req_valid = 2'b00;
         end
         #1;
         if (c < 4) chk($sformatf("b2b_c%0d_ready", c), 64'(bus_b.req_ready), 64'h1);
         chk($sformatf("b2b_c%0d_valid", c), 64'(bus_b.rsp_valid), 64'((c >= 2 && c <= 5) ? 1 : 0));
         if (c >= 2)
            chk($sformatf("b2b_c%0d_rdata", c), 64'(bus_b.rsp_rdata[31:0]),
                64'(pat_d(3, (c > 5) ? 3 : c - 2)));
      end

      // reset while a read is in flight drops its response
      @(negedge clk);
      bus_b.req_valid = 2'b01;
      bus_b.req_addr  = {6'h00, 6'h07};
      #1;
      chk("drop_ready", 64'(bus_b.req_ready), 64'h1);
      @(negedge clk);
      bus_b.req_valid = 2'b00;
      rst_b = 1'b1;
      #1;
      chk("drop_ready_in_rst", 64'(bus_b.req_ready), 64'h0);
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("drop_rsp_valid", 64'(bus_b.rsp_valid), 64'h0);
      chk("drop_done", 64'(done_b), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
